// File: rtl/onbellek_temizleyici_pkg.sv
// Shared types and constants for the L1 flush/clean sequencer.
package onbellek_temizleyici_pkg;

    localparam int SET_SAYISI = 256;
    localparam int IDX_W      = 8;
    localparam int TAG_W      = 9;
    localparam int SATIR_W    = TAG_W + 32;
    localparam logic [31:0] ADR_TABAN_VARSAYILAN = 32'h4000_0000;

    typedef enum logic [2:0] {
        BOSTA, OKU, GY0, GY1, YAZ0, YAZ1, BITTI
    } durum_t;

    typedef struct packed {
        logic [SATIR_W-1:0] satir0;
        logic [SATIR_W-1:0] satir1;
        logic               lru;
        logic [1:0]         valid;
        logic [1:0]         dirty;
    } kayit_t;

    function automatic logic [31:0] gy_adres(input logic [31:0] taban,
                                             input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
        return taban | {13'd0, tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/onbellek_temizleyici.sv
// Flush/clean sequencer and way-RAM port arbiter for the 2-way L1 data cache.
// Optional writeback counter: define ONBELLEK_SAYAC_EN.
module onbellek_temizleyici
    import onbellek_temizleyici_pkg::*;
#(
    parameter logic [31:0] ADR_TABAN = ADR_TABAN_VARSAYILAN
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush_req_i,
    input  logic                flush_inv_i,
    output logic                flush_busy_o,
    output logic                flush_done_o,
    output logic                cek_bekle_o,
    input  logic [1:0]          cek_EN0_i,
    input  logic [IDX_W-1:0]    cek_A0_i,
    input  logic [SATIR_W-1:0]  cek_Di0_i,
    input  logic [3:0]          cek_WE0_i,
    input  logic                cek_lru_i,
    input  logic [1:0]          cek_valid_i,
    input  logic [1:0]          cek_dirty_i,
    output logic                yol0_EN0,
    output logic                yol1_EN0,
    output logic [IDX_W-1:0]    yol_A0,
    output logic [SATIR_W-1:0]  yol_Di0,
    output logic [3:0]          yol_WE0,
    output logic                lru_o,
    output logic [1:0]          yol_valid_o,
    output logic [1:0]          yol_dirty_o,
    input  logic [SATIR_W-1:0]  yol0_Do0,
    input  logic [SATIR_W-1:0]  yol1_Do0,
    input  logic                lru_i,
    input  logic [1:0]          yol_valid_i,
    input  logic [1:0]          yol_dirty_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [31:0]         wb_addr_o,
    output logic [31:0]         wb_data_o,
    output logic [9:0]          geri_yazilan_o
);

    localparam logic [IDX_W-1:0] SON_IDX = IDX_W'(SET_SAYISI - 1);

    durum_t           r_durum, w_sonraki;
    logic [IDX_W-1:0] r_idx;
    logic             r_inv;
    kayit_t           r_kayit;
    logic             w_kirli0, w_kirli1, w_wb0, w_wb1;
    logic             w_v0, w_v1;

    assign w_kirli0 = r_kayit.valid[0] & r_kayit.dirty[0];
    assign w_kirli1 = r_kayit.valid[1] & r_kayit.dirty[1];
    assign w_wb0    = (r_durum == GY0) & w_kirli0;
    assign w_wb1    = (r_durum == GY1) & w_kirli1;
    assign w_v0     = r_inv ? 1'b0 : r_kayit.valid[0];
    assign w_v1     = r_inv ? 1'b0 : r_kayit.valid[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_durum <= BOSTA;
            r_idx   <= '0;
            r_inv   <= 1'b0;
            r_kayit <= '0;
        end else begin
            r_durum <= w_sonraki;
            case (r_durum)
                BOSTA: if (flush_req_i) begin
                    r_idx <= '0;
                    r_inv <= flush_inv_i;
                end
                OKU:  r_kayit <= {yol0_Do0, yol1_Do0, lru_i, yol_valid_i, yol_dirty_i};
                YAZ1: if (r_idx != SON_IDX) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // A clean way0 skips its request slot, so an all-clean set costs four cycles.
    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOSTA: if (flush_req_i) w_sonraki = OKU;
            OKU:   w_sonraki = (yol_valid_i[0] & yol_dirty_i[0]) ? GY0 : GY1;
            GY0:   if (!w_kirli0 || wb_ready_i) w_sonraki = GY1;
            GY1:   if (!w_kirli1 || wb_ready_i) w_sonraki = YAZ0;
            YAZ0:  w_sonraki = YAZ1;
            YAZ1:  w_sonraki = (r_idx == SON_IDX) ? BITTI : OKU;
            BITTI: w_sonraki = BOSTA;
            default: w_sonraki = BOSTA;
        endcase
    end

    always_comb begin
        yol0_EN0    = 1'b0;
        yol1_EN0    = 1'b0;
        yol_A0      = r_idx;
        yol_Di0     = '0;
        yol_WE0     = 4'h0;
        lru_o       = r_kayit.lru;
        yol_valid_o = r_kayit.valid;
        yol_dirty_o = r_kayit.dirty;
        case (r_durum)
            BOSTA: begin
                yol0_EN0    = cek_EN0_i[0];
                yol1_EN0    = cek_EN0_i[1];
                yol_A0      = cek_A0_i;
                yol_Di0     = cek_Di0_i;
                yol_WE0     = cek_WE0_i;
                lru_o       = cek_lru_i;
                yol_valid_o = cek_valid_i;
                yol_dirty_o = cek_dirty_i;
            end
            // Tag RAMs share yol_Di0, so each way is rewritten in its own cycle.
            YAZ0: begin
                yol0_EN0    = 1'b1;
                yol_Di0     = r_kayit.satir0;
                yol_valid_o = {r_kayit.valid[1], w_v0};
                yol_dirty_o = {r_kayit.dirty[1], 1'b0};
            end
            YAZ1: begin
                yol1_EN0    = 1'b1;
                yol_Di0     = r_kayit.satir1;
                yol_valid_o = {w_v1, w_v0};
                yol_dirty_o = 2'b00;
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_addr_o = '0;
        wb_data_o = '0;
        if (w_wb0) begin
            wb_addr_o = gy_adres(ADR_TABAN, r_kayit.satir0[SATIR_W-1:32], r_idx);
            wb_data_o = r_kayit.satir0[31:0];
        end else if (w_wb1) begin
            wb_addr_o = gy_adres(ADR_TABAN, r_kayit.satir1[SATIR_W-1:32], r_idx);
            wb_data_o = r_kayit.satir1[31:0];
        end
    end

    assign wb_valid_o   = w_wb0 | w_wb1;
    assign flush_busy_o = (r_durum != BOSTA);
    assign cek_bekle_o  = flush_busy_o;
    assign flush_done_o = (r_durum == BITTI);

`ifdef ONBELLEK_SAYAC_EN
    logic [9:0] r_sayac;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_sayac <= '0;
        else if (r_durum == BOSTA && flush_req_i)
            r_sayac <= '0;
        else if (wb_valid_o && wb_ready_i)
            r_sayac <= r_sayac + 10'd1;
    end
    assign geri_yazilan_o = r_sayac;
`else
    assign geri_yazilan_o = '0;
`endif

endmodule

// File: tb/tb_onbellek_temizleyici.sv
// Randomized bench for onbellek_temizleyici with a behavioural cache-array model.
module tb_onbellek_temizleyici;

    localparam logic [31:0] TABAN = 32'h4000_0000;

    logic        clk, resetn;
    logic        flush_req_i, flush_inv_i, flush_busy_o, flush_done_o, cek_bekle_o;
    logic [1:0]  cek_EN0_i;
    logic [7:0]  cek_A0_i;
    logic [40:0] cek_Di0_i;
    logic [3:0]  cek_WE0_i;
    logic        cek_lru_i;
    logic [1:0]  cek_valid_i, cek_dirty_i;
    logic        yol0_EN0, yol1_EN0;
    logic [7:0]  yol_A0;
    logic [40:0] yol_Di0;
    logic [3:0]  yol_WE0;
    logic        lru_o;
    logic [1:0]  yol_valid_o, yol_dirty_o;
    logic [40:0] yol0_Do0, yol1_Do0;
    logic        lru_i;
    logic [1:0]  yol_valid_i, yol_dirty_i;
    logic        wb_valid_o, wb_ready_i;
    logic [31:0] wb_addr_o, wb_data_o;
    logic [9:0]  geri_yazilan_o;

    onbellek_temizleyici dut (
        .clk(clk), .resetn(resetn),
        .flush_req_i(flush_req_i), .flush_inv_i(flush_inv_i),
        .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .cek_bekle_o(cek_bekle_o),
        .cek_EN0_i(cek_EN0_i), .cek_A0_i(cek_A0_i), .cek_Di0_i(cek_Di0_i), .cek_WE0_i(cek_WE0_i),
        .cek_lru_i(cek_lru_i), .cek_valid_i(cek_valid_i), .cek_dirty_i(cek_dirty_i),
        .yol0_EN0(yol0_EN0), .yol1_EN0(yol1_EN0), .yol_A0(yol_A0), .yol_Di0(yol_Di0),
        .yol_WE0(yol_WE0), .lru_o(lru_o), .yol_valid_o(yol_valid_o), .yol_dirty_o(yol_dirty_o),
        .yol0_Do0(yol0_Do0), .yol1_Do0(yol1_Do0), .lru_i(lru_i),
        .yol_valid_i(yol_valid_i), .yol_dirty_i(yol_dirty_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .geri_yazilan_o(geri_yazilan_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache arrays: asynchronous read, synchronous write; ram_cmd reloads contents.
    logic [8:0]  m_tag0 [256], m_tag1 [256];
    logic [31:0] m_dat0 [256], m_dat1 [256];
    logic        m_lru  [256];
    logic [1:0]  m_val  [256], m_dir [256];
    int          ram_cmd;

    assign yol0_Do0    = {m_tag0[yol_A0], m_dat0[yol_A0]};
    assign yol1_Do0    = {m_tag1[yol_A0], m_dat1[yol_A0]};
    assign lru_i       = m_lru[yol_A0];
    assign yol_valid_i = m_val[yol_A0];
    assign yol_dirty_i = m_dir[yol_A0];

    always @(posedge clk) begin
        if (ram_cmd != 0) begin
            for (int i = 0; i < 256; i++) begin
                m_tag0[i] <= 9'($urandom);
                m_tag1[i] <= 9'($urandom);
                m_dat0[i] <= $urandom;
                m_dat1[i] <= $urandom;
                m_lru[i]  <= 1'($urandom);
                m_val[i]  <= 2'($urandom);
                m_dir[i]  <= (ram_cmd == 2) ? (2'($urandom) & 2'($urandom)) : 2'b00;
            end
            if (ram_cmd == 3) begin
                m_tag0[5] <= 9'h0F0;  m_dat0[5] <= 32'h1234_5678;
                m_tag1[5] <= 9'h1A3;  m_dat1[5] <= 32'hDEAD_BEEF;
                m_val[5]  <= 2'b10;   m_dir[5]  <= 2'b10;  m_lru[5] <= 1'b1;
            end
            if (ram_cmd == 4) begin
                m_tag0[0] <= 9'h055;  m_dat0[0] <= 32'hCAFE_F00D;
                m_val[0]  <= 2'b01;   m_dir[0]  <= 2'b01;
            end
        end else begin
            if (yol0_EN0) begin
                m_tag0[yol_A0] <= yol_Di0[40:32];
                for (int b = 0; b < 4; b++)
                    if (yol_WE0[b]) m_dat0[yol_A0][8*b +: 8] <= yol_Di0[8*b +: 8];
            end
            if (yol1_EN0) begin
                m_tag1[yol_A0] <= yol_Di0[40:32];
                for (int b = 0; b < 4; b++)
                    if (yol_WE0[b]) m_dat1[yol_A0][8*b +: 8] <= yol_Di0[8*b +: 8];
            end
            if (yol0_EN0 || yol1_EN0) begin
                m_lru[yol_A0] <= lru_o;
                m_val[yol_A0] <= yol_valid_o;
                m_dir[yol_A0] <= yol_dirty_o;
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ram_yukle(input int c);
        @(negedge clk) ram_cmd = c;
        @(negedge clk) ram_cmd = 0;
    endtask

    task automatic cek_sifirla();
        cek_EN0_i = 2'b00; cek_A0_i = '0; cek_Di0_i = '0; cek_WE0_i = '0;
        cek_lru_i = 1'b0;  cek_valid_i = '0; cek_dirty_i = '0;
    endtask

    task automatic cikis_sifir_kontrol(input string tag);
        chk({tag, "_ctl"}, 160'({flush_busy_o, flush_done_o, cek_bekle_o, yol0_EN0, yol1_EN0, yol_A0,
                                 yol_Di0, yol_WE0, lru_o, yol_valid_o, yol_dirty_o}), 160'(0));
        chk({tag, "_wb"}, 160'({wb_valid_o, wb_addr_o, wb_data_o, geri_yazilan_o}), 160'(0));
    endtask

    // Snapshot-based reference: every valid&dirty line is written back in
    // set order, way0 before way1; afterwards dirty is clear everywhere, valid
    // is kept (or cleared when invalidating) and tags/data/lru are untouched.
    // bekle<0 gives random ready plus core noise during the flush.
    task automatic flush_calistir(input logic inv, input int bekle, input bit cift,
                                  output int done_cyc, output int son_tutma);
        logic [8:0]  s_tag0 [256], s_tag1 [256];
        logic [31:0] s_dat0 [256], s_dat1 [256];
        logic        s_lru  [256];
        logic [1:0]  s_val  [256], s_dir [256];
        logic [63:0] q [$];
        logic [63:0] e;
        logic [31:0] p_addr, p_data;
        logic [7:0]  a;
        int cyc, hold, n_hs, n_bek, stab_err, extra, done_cnt, exp_cnt;
        int e_dir, e_val, e_tag, e_dat, e_lru;
        bit bekliyor, bitti;
        for (int i = 0; i < 256; i++) begin
            s_tag0[i] = m_tag0[i]; s_tag1[i] = m_tag1[i];
            s_dat0[i] = m_dat0[i]; s_dat1[i] = m_dat1[i];
            s_lru[i]  = m_lru[i];  s_val[i]  = m_val[i];  s_dir[i] = m_dir[i];
        end
        for (int i = 0; i < 256; i++) begin
            if (s_val[i][0] && s_dir[i][0])
                q.push_back({TABAN | {13'd0, s_tag0[i], 8'(i), 2'b00}, s_dat0[i]});
            if (s_val[i][1] && s_dir[i][1])
                q.push_back({TABAN | {13'd0, s_tag1[i], 8'(i), 2'b00}, s_dat1[i]});
        end
        n_bek = q.size();
        cyc = 0; hold = 0; n_hs = 0; stab_err = 0; extra = 0; done_cnt = 0;
        bekliyor = 0; bitti = 0; done_cyc = -1; son_tutma = 0;
        p_addr = '0; p_data = '0;

        @(negedge clk);
        a = 8'($urandom);
        flush_req_i = 1'b1; flush_inv_i = inv; cek_A0_i = a;
        #1 chk("accept_passthru", 160'(yol_A0), 160'(a));
        @(negedge clk);
        flush_req_i = 1'b0; flush_inv_i = 1'b0; cek_A0_i = '0; cyc = 1;
        chk("busy_after_accept", 160'({flush_busy_o, cek_bekle_o}), 160'(2'b11));
        if (bekle < 0) begin
            cek_EN0_i = 2'b11; cek_WE0_i = 4'hF; cek_A0_i = 8'($urandom);
            cek_Di0_i = {9'($urandom), $urandom}; cek_lru_i = 1'b1;
            cek_valid_i = 2'b11; cek_dirty_i = 2'b11;
        end
        while (!bitti && cyc < 6000) begin
            if (cift) flush_req_i = (cyc == 10 || cyc == 500);
            if (bekliyor && (!wb_valid_o || wb_addr_o != p_addr || wb_data_o != p_data))
                stab_err++;
            bekliyor = 0;
            if (flush_done_o) begin
                done_cnt++; done_cyc = cyc; bitti = 1;
                cek_sifirla(); wb_ready_i = 1'b0;
            end else if (wb_valid_o) begin
                hold++;
                wb_ready_i = (bekle < 0) ? ($urandom_range(0, 2) == 0) : (hold > bekle);
                if (wb_ready_i) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("wb_addr", 160'(wb_addr_o), 160'(e[63:32]));
                        chk("wb_data", 160'(wb_data_o), 160'(e[31:0]));
                    end else extra++;
                    n_hs++; son_tutma = hold; hold = 0;
                end else begin
                    bekliyor = 1; p_addr = wb_addr_o; p_data = wb_data_o;
                end
            end else begin
                wb_ready_i = (bekle < 0) ? 1'($urandom) : 1'b0;
            end
            if (!bitti) begin
                @(negedge clk);
                cyc++;
            end
        end
        flush_req_i = 1'b0; wb_ready_i = 1'b0; cek_sifirla();
        chk("done_seen", 160'(bitti), 160'(1));
        repeat (6) begin
            @(negedge clk);
            if (flush_done_o) done_cnt++;
        end
        chk("done_pulses", 160'(done_cnt), 160'(1));
        chk("busy_after_done", 160'({flush_busy_o, cek_bekle_o}), 160'(0));
        chk("wb_stable", 160'(stab_err), 160'(0));
        chk("wb_count", 160'(n_hs), 160'(n_bek));
        chk("wb_extra", 160'(extra), 160'(0));
`ifdef ONBELLEK_SAYAC_EN
        exp_cnt = n_bek;
`else
        exp_cnt = 0;
`endif
        chk("geri_yazilan", 160'(geri_yazilan_o), 160'(exp_cnt));
        e_dir = 0; e_val = 0; e_tag = 0; e_dat = 0; e_lru = 0;
        for (int i = 0; i < 256; i++) begin
            if (m_dir[i] != 2'b00) e_dir++;
            if (m_val[i] != (inv ? 2'b00 : s_val[i])) e_val++;
            if (m_tag0[i] != s_tag0[i] || m_tag1[i] != s_tag1[i]) e_tag++;
            if (m_dat0[i] != s_dat0[i] || m_dat1[i] != s_dat1[i]) e_dat++;
            if (m_lru[i] != s_lru[i]) e_lru++;
        end
        chk("final_dirty", 160'(e_dir), 160'(0));
        chk("final_valid", 160'(e_val), 160'(0));
        chk("final_tag",   160'(e_tag), 160'(0));
        chk("final_data",  160'(e_dat), 160'(0));
        chk("final_lru",   160'(e_lru), 160'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, st, k;
        logic [40:0] di;
        logic [4:0]  md;
        resetn = 1'b0; ram_cmd = 0;
        flush_req_i = 1'b0; flush_inv_i = 1'b0; wb_ready_i = 1'b0;
        cek_sifirla();
        #12 cikis_sifir_kontrol("reset");
        @(negedge clk) resetn = 1'b1;

        // Idle pass-through, two patterns.
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            di = {9'($urandom), $urandom};
            md = 5'($urandom);
            cek_EN0_i = (p == 0) ? 2'b01 : 2'b10;
            cek_A0_i  = (p == 0) ? 8'h12 : 8'($urandom);
            cek_WE0_i = (p == 0) ? 4'hF : 4'($urandom);
            cek_Di0_i = di;
            {cek_lru_i, cek_valid_i, cek_dirty_i} = md;
            #1;
            chk("pt_yol", 160'({yol1_EN0, yol0_EN0, yol_A0, yol_Di0, yol_WE0,
                                lru_o, yol_valid_o, yol_dirty_o}),
                          160'({cek_EN0_i, cek_A0_i, di, cek_WE0_i, md}));
            chk("pt_stall", 160'({cek_bekle_o, flush_busy_o, wb_valid_o}), 160'(0));
            #1 cek_sifirla();
        end

        ram_yukle(1);
        flush_calistir(1'b0, 0, 1'b0, dc, st);
        chk("clean_done_cycle", 160'(dc), 160'(1025));

        ram_yukle(3);
        flush_calistir(1'b0, 0, 1'b0, dc, st);
        chk("set5_clean", 160'({m_val[5], m_dir[5], m_lru[5], m_tag1[5], m_dat1[5]}),
                          160'({2'b10, 2'b00, 1'b1, 9'h1A3, 32'hDEAD_BEEF}));

        ram_yukle(3);
        flush_calistir(1'b1, 7, 1'b0, dc, st);
        chk("hold_len", 160'(st), 160'(8));
        chk("set5_inv", 160'({m_val[5], m_dir[5], m_tag1[5]}), 160'({2'b00, 2'b00, 9'h1A3}));

        // Reset while the set-0 writeback is pending.
        ram_yukle(4);
        @(negedge clk) flush_req_i = 1'b1;
        @(negedge clk) flush_req_i = 1'b0;
        k = 0;
        while (!wb_valid_o && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("gy0_reached", 160'(wb_valid_o), 160'(1));
        #2 resetn = 1'b0;
        #1 cikis_sifir_kontrol("midflush_reset");
        @(negedge clk) resetn = 1'b1;
        flush_calistir(1'b0, 0, 1'b0, dc, st);

        ram_yukle(2);
        flush_calistir(1'($urandom), -1, 1'b0, dc, st);
        ram_yukle(2);
        flush_calistir(1'b1, -1, 1'b1, dc, st);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
